// File: rtl/axil_regbank_slave.sv
// AXI4-Lite register bank: status register 0 with sticky W1C bits,
// control registers 1..NUM_REGS-1 with one-cycle write strobes.
module axil_regbank_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          NUM_REGS           = 12,
  parameter logic [31:0] STICKY_MASK        = 32'h0000_0004
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_i,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs_o,
  output logic [NUM_REGS-1:0]                    wr_pulse_o
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int SW   = DW / 8;
  localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDXW:0] NREGS_W = NUM_REGS[IDXW:0];
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {B_IDLE, B_RESP} b_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic            ready_en_q;
  logic            aw_full_q, aw_full_d;
  logic [IDXW-1:0] aw_idx_q, aw_idx_d;
  logic            w_full_q, w_full_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  b_state_t        b_state_q, b_state_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]   regs_q [NUM_REGS];
  logic [DW-1:0]   regs_d [NUM_REGS];
  r_state_t        r_state_q, r_state_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic            aw_hs, w_hs, ar_hs, commit;
  logic            wr_in_range, rd_in_range;
  logic [IDXW-1:0] ar_idx;
  logic [DW-1:0]   wmask, clr, rd_val;
  logic            unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en_q && !aw_full_q;
  assign S_AXI_WREADY  = ready_en_q && !w_full_q;
  assign S_AXI_ARREADY = ready_en_q && (r_state_q == R_IDLE);
  assign S_AXI_BVALID  = (b_state_q == B_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o    = pulse_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full_q && w_full_q && (b_state_q == B_IDLE);
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_in_range = ({1'b0, aw_idx_q} < NREGS_W);
  assign rd_in_range = ({1'b0, ar_idx} < NREGS_W);

  // Expand buffered byte strobes to a bit mask
  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      wmask[8*i +: 8] = {8{wstrb_q[i]}};
    end
  end

  // AW and W buffers fill independently and drain together on commit
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end
    end
  end

  // Write response state and registered response code
  always_comb begin
    b_state_d = b_state_q;
    bresp_d   = bresp_q;
    unique case (b_state_q)
      B_IDLE: if (commit) begin
        b_state_d = B_RESP;
        bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      B_RESP: if (S_AXI_BREADY) b_state_d = B_IDLE;
      default: b_state_d = B_IDLE;
    endcase
  end

  // Register update: status sampling with sticky W1C, control writes and strobes
  always_comb begin
    pulse_d = '0;
    clr     = '0;
    regs_d  = regs_q;
    if (commit && wr_in_range && (aw_idx_q == '0)) begin
      clr = wdata_q & wmask & STICKY_MASK;
    end
    // Sticky set is applied after the clear so a coincident set wins
    regs_d[0] = (status_i & ~STICKY_MASK)
              | (((regs_q[0] & ~clr) | status_i) & STICKY_MASK);
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (commit && wr_in_range && (aw_idx_q == IDXW'(i))) begin
        regs_d[i]  = (regs_q[i] & ~wmask) | (wdata_q & wmask);
        pulse_d[i] = 1'b1;
      end
    end
  end

  // Read mux; out-of-range indices match nothing and return zero
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDXW'(i)) rd_val = regs_q[i];
    end
  end

  // Read channel state and captured data/response
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        rdata_d   = rd_in_range ? rd_val : '0;
        rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Flatten register array onto the output bus
  always_comb begin
    ctrl_regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      ctrl_regs_o[i*DW +: DW] = regs_q[i];
    end
  end

  // FSM state registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      b_state_q <= B_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      b_state_q <= b_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Datapath registers; ready_en_q holds READYs low until the first edge after reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
      pulse_q    <= '0;
      regs_q     <= '{default: '0};
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      pulse_q    <= pulse_d;
      regs_q     <= regs_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Directed bench for axil_regbank_slave (12 registers, sticky bit 2).
module tb_axil_regbank_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata, status;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [383:0] ctrl;
  logic [11:0]  wr_pulse;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [31:0]  exp_r [12];
  logic [1:0]   resp;
  logic [11:0]  pls;
  logic [31:0]  rd;

  always #5 clk = ~clk;

  axil_regbank_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(12),
    .STICKY_MASK(32'h0000_0004)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .status_i(status), .ctrl_regs_o(ctrl), .wr_pulse_o(wr_pulse)
  );

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [383:0] exp_flat();
    logic [383:0] f;
    for (int i = 0; i < 12; i++) f[i*32 +: 32] = exp_r[i];
    return f;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit ack, output logic [1:0] r, output logic [11:0] p);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 10 && !bvalid; k++) tick;
    if (!bvalid) check_eq("bvalid_timeout", bvalid, 1);
    r = bresp; p = wr_pulse;
    if (ack) begin
      bready = 1'b1; tick; bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    for (int k = 0; k < 10 && !rvalid; k++) tick;
    if (!rvalid) check_eq("rvalid_timeout", rvalid, 1);
    d = rdata; r = rresp;
    rready = 1'b1; tick; rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b0; arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0; status = '0;
    for (int i = 0; i < 12; i++) exp_r[i] = '0;
    repeat (3) tick;

    // Reset state
    check_eq("rst_readys", {awready, wready, arready}, 0);
    check_eq("rst_valids", {bvalid, rvalid}, 0);
    check_eq("rst_resps", {bresp, rresp}, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_regs", ctrl, 0);
    check_eq("rst_pulse", wr_pulse, 0);
    rst_n = 1'b1;
    #2;
    check_eq("ready_pre_edge", {awready, wready, arready}, 0);
    tick;
    check_eq("ready_after_edge", {awready, wready, arready}, 3'b111);

    // AW and W together
    do_write(6'h04, 32'hDEADBEEF, 4'hF, 1'b1, resp, pls);
    exp_r[1] = 32'hDEADBEEF;
    check_eq("wr1_bresp", resp, 2'b00);
    check_eq("wr1_pulse", pls, 12'h002);
    check_eq("wr1_regs", ctrl, exp_flat());
    check_eq("wr1_pulse_gone", wr_pulse, 0);
    check_eq("wr1_bvalid_drop", bvalid, 0);
    do_read(6'h04, rd, resp);
    check_eq("rd1_data", rd, 32'hDEADBEEF);
    check_eq("rd1_resp", resp, 2'b00);

    // W three cycles ahead of AW, partial strobes, BREADY held low
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    check_eq("w_buffered_wready", wready, 0);
    check_eq("w_buffered_awready", awready, 1);
    tick; tick;
    awaddr = 6'h08; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    for (int k = 0; k < 10 && !bvalid; k++) tick;
    exp_r[2] = 32'h00220044;
    check_eq("wr2_bvalid", bvalid, 1);
    check_eq("wr2_pulse", wr_pulse, 12'h004);
    check_eq("wr2_regs", ctrl, exp_flat());
    for (int k = 0; k < 5; k++) begin
      tick;
      check_eq("wr2_bhold", {bvalid, bresp}, 3'b100);
    end
    bready = 1'b1; tick; bready = 1'b0;
    check_eq("wr2_bclear", bvalid, 0);

    // Out of range and top register boundary
    do_write(6'h30, 32'hA5A5A5A5, 4'hF, 1'b1, resp, pls);
    check_eq("oor_bresp", resp, 2'b10);
    check_eq("oor_pulse", pls, 0);
    check_eq("oor_regs", ctrl, exp_flat());
    do_read(6'h3C, rd, resp);
    check_eq("oor_rdata", rd, 0);
    check_eq("oor_rresp", resp, 2'b10);
    do_write(6'h2C, 32'hCAFEF00D, 4'hF, 1'b1, resp, pls);
    exp_r[11] = 32'hCAFEF00D;
    check_eq("top_bresp", resp, 2'b00);
    check_eq("top_pulse", pls, 12'h800);
    do_read(6'h2D, rd, resp);
    check_eq("top_rdata", rd, 32'hCAFEF00D);
    check_eq("top_rresp", resp, 2'b00);

    // Zero strobes: OKAY, pulse, no data change
    do_write(6'h0C, 32'hFFFFFFFF, 4'h0, 1'b1, resp, pls);
    check_eq("nostrb_bresp", resp, 2'b00);
    check_eq("nostrb_pulse", pls, 12'h008);
    check_eq("nostrb_regs", ctrl, exp_flat());

    // Sticky done bit
    status = 32'h4; tick; status = 32'h0; tick;
    check_eq("sticky_hold", ctrl[31:0], 32'h4);
    do_read(6'h00, rd, resp);
    check_eq("sticky_read", rd, 32'h4);
    do_write(6'h00, 32'h4, 4'hF, 1'b1, resp, pls);
    check_eq("w1c_bresp", resp, 2'b00);
    check_eq("w1c_no_pulse", pls, 0);
    check_eq("w1c_cleared", ctrl[31:0], 32'h0);

    // Non-sticky bits follow status and ignore writes
    status = 32'h3; tick;
    check_eq("live_status", ctrl[31:0], 32'h3);
    do_write(6'h00, 32'hFFFFFFFF, 4'hF, 1'b1, resp, pls);
    check_eq("live_after_write", ctrl[31:0], 32'h3);
    status = 32'h0; tick;
    check_eq("live_drop", ctrl[31:0], 32'h0);

    // Clear coincident with a new set: set wins
    status = 32'h4; tick; status = 32'h0;
    awaddr = 6'h00; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; status = 32'h4;
    tick;
    status = 32'h0;
    check_eq("coinc_bvalid", bvalid, 1);
    check_eq("coinc_bit2", ctrl[31:0], 32'h4);
    bready = 1'b1; tick; bready = 1'b0;
    do_read(6'h00, rd, resp);
    check_eq("coinc_read", rd, 32'h4);
    do_write(6'h00, 32'h4, 4'b1110, 1'b1, resp, pls);
    check_eq("w1c_strb_masked", ctrl[31:0], 32'h4);
    do_write(6'h00, 32'h4, 4'b0001, 1'b1, resp, pls);
    check_eq("w1c_strb_lane0", ctrl[31:0], 32'h0);

    // Reset while a response is pending and an AW is buffered
    do_write(6'h14, 32'h12345678, 4'hF, 1'b0, resp, pls);
    check_eq("pend_bvalid", bvalid, 1);
    awaddr = 6'h18; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    check_eq("aw_buffered", awready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {awready, wready, arready, bvalid, rvalid, bresp}, 0);
    check_eq("async_rst_regs", ctrl, 0);
    check_eq("async_rst_pulse", wr_pulse, 0);
    for (int i = 0; i < 12; i++) exp_r[i] = '0;
    tick;
    rst_n = 1'b1;
    tick;
    check_eq("rerelease_ready", {awready, wready, arready}, 3'b111);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    repeat (3) tick;
    check_eq("aw_lost_no_resp", bvalid, 0);
    check_eq("aw_lost_regs", ctrl, exp_flat());
    do_read(6'h04, rd, resp);
    check_eq("post_rst_read", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
